serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 15 +
 rtl/serial_subtractor_full_subtractor.sv | 20 ++
 rtl/serial_subtractor.sv | 119 +++++++++++
 tb/tb_serial_subtractor.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   DEFAULT_WIDTH : default operand width in bits
//   state_t       : control FSM states (idle, running, result-ready)
package serial_subtractor_pkg;

   localparam int DEFAULT_WIDTH = 8;

   // The ST_ prefix keeps the state names clear of the DONE output port.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: computes A - B - B_in for one bit position.
//   A     : minuend bit
//   B     : subtrahend bit
//   B_in  : borrow from the less significant bit
//   D     : difference bit
//   B_out : borrow to the more significant bit
module full_subtractor (
   input  logic A,
   input  logic B,
   input  logic B_in,
   output logic D,
   output logic B_out
);

   assign D     = A ^ B ^ B_in;
   // Borrow when the minuend bit is 0 and the subtrahend bit is 1, or when
   // the bits are equal and a borrow is already pending.
   assign B_out = (~A & B) | (~(A ^ B) & B_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - B_in, one bit per clock, LSB first.
//   CLK   : clock, rising edge active
//   RST_n : asynchronous active-low reset
//   START : begin a subtraction (sampled only while idle)
//   A, B  : minuend / subtrahend, captured on the accepting edge
//   B_in  : borrow-in, captured on the accepting edge
//   BUSY  : high while bits are being processed
//   DONE  : one-cycle pulse when D/B_out hold a new result
//   D     : registered difference
//   B_out : registered borrow-out (A < B + B_in, unsigned)
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             CLK,
   input  logic             RST_n,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             B_in,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] D,
   output logic             B_out
);

   // Wide enough to hold WIDTH itself, so it never wraps inside an operation.
   localparam int            CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             borrow;
   logic [CW-1:0]    cnt;
   logic             fs_d;
   logic             fs_bout;
   logic             last_bit;

   full_subtractor u_fs (
      .A     (a_sr[0]),
      .B     (b_sr[0]),
      .B_in  (borrow),
      .D     (fs_d),
      .B_out (fs_bout)
   );

   assign last_bit = (cnt == LAST_BIT);

   // NOTE: every output of this block gets a default first so no path through
   // the case statement leaves a signal unassigned and infers a latch.
   always_comb begin
      state_next = state;
      BUSY       = 1'b0;
      DONE       = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (START) state_next = ST_RUN;
         end
         ST_RUN: begin
            BUSY = 1'b1;
            if (last_bit) state_next = ST_DONE;
         end
         ST_DONE: begin
            DONE       = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         D      <= '0;
         B_out  <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (START) begin
                  a_sr   <= A;
                  b_sr   <= B;
                  borrow <= B_in;
                  cnt    <= '0;
               end
            end
            ST_RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               borrow <= fs_bout;
               res_sr <= {fs_d, res_sr[WIDTH-1:1]};
               cnt    <= cnt + CW'(1);
               // The visible result only changes on the final bit edge, so
               // partial shifting never appears on D.
               if (last_bit) begin
                  D     <= {fs_d, res_sr[WIDTH-1:1]};
                  B_out <= fs_bout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 8): directed vector
// table, start-during-run and reset-during-run sequences, and randomized
// operands checked against an arithmetic reference model.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         CLK;
   logic         RST_n;
   logic         START;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         B_in;
   logic         BUSY;
   logic         DONE;
   logic [W-1:0] D;
   logic         B_out;

   int n_vec  = 0;
   int n_fail = 0;
   int done_seen = 0;
   int ops_done  = 0;
   int overlap   = 0;

   logic [W-1:0] last_d;
   logic         last_bout;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] d;
      logic         bout;
   } vec_t;

   vec_t vecs[6];

   serial_subtractor #(.WIDTH(W)) dut (
      .CLK   (CLK),
      .RST_n (RST_n),
      .START (START),
      .A     (A),
      .B     (B),
      .B_in  (B_in),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .D     (D),
      .B_out (B_out)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(negedge CLK) begin
      if (DONE === 1'b1) done_seen++;
      if (BUSY === 1'b1 && DONE === 1'b1) overlap++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain unsigned arithmetic on the whole operands.
   task automatic model(input int a, input int b, input int bin,
                        output logic [W-1:0] d, output logic bout);
      int diff;
      diff = a - b - bin;
      d    = diff[W-1:0];
      bout = (a < (b + bin));
   endtask

   // Starts an operation at a negedge with the DUT idle. Optionally pulses
   // START with new operands at RUN cycle start_at, or asserts reset at RUN
   // cycle rst_at. Returns at a negedge with the DUT idle (or in reset).
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input int start_at, input int rst_at,
                        output logic [W-1:0] d, output logic bout,
                        output int lat, output bit aborted);
      bit done;
      int n;
      A = a; B = b; B_in = bin; START = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      START = 1'b0;
      A = W'($urandom); B = W'($urandom); B_in = 1'($urandom);
      n = 0; done = 1'b0; aborted = 1'b0; lat = 0;
      d = '0; bout = 1'b0;
      while (!done && n < 20) begin
         @(posedge CLK);
         n++;
         @(negedge CLK);
         if (DONE === 1'b1) begin
            done = 1'b1;
            lat  = n;
            d    = D;
            bout = B_out;
            check("busy_at_done", 32'(BUSY), 32'd0);
         end else begin
            check("busy_run", 32'(BUSY), 32'd1);
            check("d_hold", 32'(D), 32'(last_d));
            check("bout_hold", 32'(B_out), 32'(last_bout));
         end
         if (!done && n == start_at) begin
            START = 1'b1; A = 8'h10; B = 8'h01;
         end else begin
            START = 1'b0;
         end
         if (!done && n == rst_at) begin
            RST_n = 1'b0;
            #1;
            check("rst_busy", 32'(BUSY), 32'd0);
            check("rst_done", 32'(DONE), 32'd0);
            check("rst_d", 32'(D), 32'd0);
            check("rst_bout", 32'(B_out), 32'd0);
            aborted = 1'b1;
            break;
         end
      end
      START = 1'b0;
      if (!aborted) begin
         check("done_timeout", 32'(done), 32'd1);
         if (done) ops_done++;
         @(posedge CLK);
         @(negedge CLK);
         check("done_width", 32'(DONE), 32'd0);
         check("idle_busy", 32'(BUSY), 32'd0);
      end
   endtask

   initial begin
      logic [W-1:0] d, exp_d;
      logic         bout, exp_bout;
      int           lat;
      bit           aborted;
      logic [W-1:0] ra, rb;
      logic         rbin;

      vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
      vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
      vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[3] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
      vecs[4] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
      vecs[5] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};

      RST_n = 1'b1; START = 1'b0; A = '0; B = '0; B_in = 1'b0;
      #2 RST_n = 1'b0;
      repeat (3) @(negedge CLK);
      check("reset_busy", 32'(BUSY), 32'd0);
      check("reset_done", 32'(DONE), 32'd0);
      check("reset_d", 32'(D), 32'd0);
      check("reset_bout", 32'(B_out), 32'd0);
      RST_n = 1'b1;
      last_d = '0; last_bout = 1'b0;

      // Directed table; the first operation starts on the first edge after reset release.
      for (int i = 0; i < 6; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].bin, 0, 0, d, bout, lat, aborted);
         check($sformatf("vec%0d_d", i), 32'(d), 32'(vecs[i].d));
         check($sformatf("vec%0d_bout", i), 32'(bout), 32'(vecs[i].bout));
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(W));
         last_d = vecs[i].d; last_bout = vecs[i].bout;
      end

      // START pulsed mid-run must be ignored.
      do_op(8'h09, 8'h04, 1'b0, 3, 0, d, bout, lat, aborted);
      check("midstart_d", 32'(d), 32'h05);
      check("midstart_bout", 32'(bout), 32'd0);
      last_d = 8'h05; last_bout = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         check("midstart_no_rerun", 32'(BUSY | DONE), 32'd0);
      end

      // Reset mid-run aborts with no DONE pulse.
      do_op(8'h33, 8'h11, 1'b0, 0, 4, d, bout, lat, aborted);
      check("rst_aborted", 32'(aborted), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         check("rst_hold_done", 32'(DONE), 32'd0);
         check("rst_hold_d", 32'(D), 32'd0);
      end
      RST_n = 1'b1;
      last_d = '0; last_bout = 1'b0;
      @(negedge CLK);
      check("post_rst_idle", 32'(DONE | BUSY), 32'd0);
      do_op(8'h0A, 8'h0A, 1'b0, 0, 0, d, bout, lat, aborted);
      check("post_rst_d", 32'(d), 32'h00);
      check("post_rst_bout", 32'(bout), 32'd0);
      check("post_rst_latency", 32'(lat), 32'(W));
      last_d = 8'h00; last_bout = 1'b0;

      // Randomized operands against the arithmetic model.
      for (int i = 0; i < 500; i++) begin
         ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
         model(int'(ra), int'(rb), int'(rbin), exp_d, exp_bout);
         do_op(ra, rb, rbin, 0, 0, d, bout, lat, aborted);
         check($sformatf("rand a=%0h b=%0h bin=%0d d", ra, rb, rbin), 32'(d), 32'(exp_d));
         check($sformatf("rand a=%0h b=%0h bin=%0d bout", ra, rb, rbin), 32'(bout), 32'(exp_bout));
         check("rand_latency", 32'(lat), 32'(W));
         last_d = exp_d; last_bout = exp_bout;
      end

      @(negedge CLK);
      check("done_count", 32'(done_seen), 32'(ops_done));
      check("busy_done_overlap", 32'(overlap), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
